// File: rtl/commit_trace_buf.sv
// commit_trace_buf: classifies retiring instructions into numbered trace records,
// buffers them in a first-word-fall-through FIFO and drains them over valid/ready.
// Latency: a record pushed into an empty FIFO is presented on out_* the next cycle.
// Backpressure: out_ready low holds the head stable; a push into a full FIFO with no
// pop is dropped and flags overflow (or, with COMMIT_TRACE_STALL_EN defined,
// commit_stall asks the processor to hold its commit instead).
// Ports: commit_* / reg_* / mem_* / halt in from retire; out_* valid/ready record
// stream; full, overflow, inst_count, cycle_count, done status.
// Optional macro: COMMIT_TRACE_STALL_EN adds commit_stall and ties overflow to 0.
module commit_trace_buf #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             commit_valid,
   input  logic [15:0]      commit_pc,
   input  logic             reg_write,
   input  logic [2:0]       write_reg,
   input  logic [15:0]      write_data,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic [15:0]      mem_addr,
   input  logic [15:0]      mem_data,
   input  logic             halt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       out_kind,
   output logic [15:0]      out_inum,
   output logic [15:0]      out_pc,
   output logic [2:0]       out_reg,
   output logic [15:0]      out_value,
   output logic [15:0]      out_addr,
   output logic [15:0]      out_mdata,
   output logic             full,
   output logic             overflow,
   output logic [15:0]      inst_count,
   output logic [CNT_W-1:0] cycle_count,
   output logic             done
`ifdef COMMIT_TRACE_STALL_EN
   ,
   output logic             commit_stall
`endif
);

   localparam int AW    = $clog2(DEPTH);
   localparam int REC_W = 86;

   localparam logic [2:0] K_OTHER = 3'd0;
   localparam logic [2:0] K_REG   = 3'd1;
   localparam logic [2:0] K_LD    = 3'd2;
   localparam logic [2:0] K_ST    = 3'd3;
   localparam logic [2:0] K_STU   = 3'd4;
   localparam logic [2:0] K_HALT  = 3'd5;

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

   state_t           r_state, w_state_nxt;
   logic [REC_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
   logic [AW:0]      r_count;
   logic [15:0]      r_inst_count;
   logic [CNT_W-1:0] r_cycle_count;

   logic             w_run, w_done;
   logic             w_valid, w_full, w_pop, w_commit, w_push;
   logic [2:0]       w_kind;
   logic             w_use_reg, w_use_addr, w_use_mdata;
   logic [REC_W-1:0] w_rec, w_out_rec;

   // Record layout: kind | inum | pc | reg | value | addr | mdata
   always_comb begin
      w_kind      = K_OTHER;
      w_use_reg   = 1'b0;
      w_use_addr  = 1'b0;
      w_use_mdata = 1'b0;
      if (halt) begin
         w_kind = K_HALT;
      end else if (reg_write && mem_write) begin
         w_kind      = K_STU;
         w_use_reg   = 1'b1;
         w_use_addr  = 1'b1;
         w_use_mdata = 1'b1;
      end else if (reg_write && mem_read) begin
         w_kind     = K_LD;
         w_use_reg  = 1'b1;
         w_use_addr = 1'b1;
      end else if (reg_write) begin
         w_kind    = K_REG;
         w_use_reg = 1'b1;
      end else if (mem_write) begin
         w_kind      = K_ST;
         w_use_addr  = 1'b1;
         w_use_mdata = 1'b1;
      end
   end

   assign w_rec = {w_kind, r_inst_count, commit_pc,
                   w_use_reg   ? write_reg  : 3'd0,
                   w_use_reg   ? write_data : 16'd0,
                   w_use_addr  ? mem_addr   : 16'd0,
                   w_use_mdata ? mem_data   : 16'd0};

   assign w_valid = (r_count != '0);
   assign w_full  = (r_count == (AW+1)'(DEPTH));
   assign w_pop   = w_valid & out_ready;

`ifdef COMMIT_TRACE_STALL_EN
   logic w_stall;
   // A full FIFO can still take a commit in the same cycle the head leaves.
   assign w_stall      = w_full & ~w_pop;
   assign w_commit     = w_run & commit_valid & ~w_stall;
   assign commit_stall = w_stall;
   assign overflow     = 1'b0;
`else
   logic r_overflow;
   assign w_commit = w_run & commit_valid;
   assign overflow = r_overflow;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (w_commit && w_full && !w_pop) begin
         r_overflow <= 1'b1;
      end
   end
`endif

   assign w_push = w_commit & (~w_full | w_pop);

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_RUN;
      else     r_state <= w_state_nxt;
   end

   // FSM: next state. A dropped HALT still ends the run.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_RUN:   if (w_commit && halt) w_state_nxt = S_DRAIN;
         S_DRAIN: if (r_count == '0)    w_state_nxt = S_DONE;
         default: w_state_nxt = r_state;
      endcase
   end

   // FSM: outputs
   always_comb begin
      w_run  = 1'b0;
      w_done = 1'b0;
      case (r_state)
         S_RUN:   w_run  = 1'b1;
         S_DONE:  w_done = 1'b1;
         default: ;
      endcase
   end

   // Storage is not reset; out_* are gated by out_valid so stale entries never show.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_rec;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_inst_count  <= '0;
         r_cycle_count <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
         if (w_commit) r_inst_count  <= r_inst_count + 16'd1;
         if (w_run)    r_cycle_count <= r_cycle_count + CNT_W'(1);
      end
   end

   assign w_out_rec = w_valid ? r_mem[r_rd_ptr] : '0;

   assign out_valid   = w_valid;
   assign out_kind    = w_out_rec[85:83];
   assign out_inum    = w_out_rec[82:67];
   assign out_pc      = w_out_rec[66:51];
   assign out_reg     = w_out_rec[50:48];
   assign out_value   = w_out_rec[47:32];
   assign out_addr    = w_out_rec[31:16];
   assign out_mdata   = w_out_rec[15:0];
   assign full        = w_full;
   assign inst_count  = r_inst_count;
   assign cycle_count = r_cycle_count;
   assign done        = w_done;

endmodule

// File: tb/tb_commit_trace_buf.sv
// tb_commit_trace_buf: directed + randomized bench for commit_trace_buf with a
// queue-based reference model of the trace buffer compared every cycle.
module tb_commit_trace_buf;

   localparam int DEPTH = 8;
   localparam int CNT_W = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        commit_valid;
   logic [15:0] commit_pc;
   logic        reg_write;
   logic [2:0]  write_reg;
   logic [15:0] write_data;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_addr;
   logic [15:0] mem_data;
   logic        halt;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  out_kind;
   logic [15:0] out_inum;
   logic [15:0] out_pc;
   logic [2:0]  out_reg;
   logic [15:0] out_value;
   logic [15:0] out_addr;
   logic [15:0] out_mdata;
   logic        full;
   logic        overflow;
   logic [15:0] inst_count;
   logic [CNT_W-1:0] cycle_count;
   logic        done;
`ifdef COMMIT_TRACE_STALL_EN
   logic        commit_stall;
`endif

   commit_trace_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .commit_valid(commit_valid), .commit_pc(commit_pc),
      .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_data(mem_data), .halt(halt),
      .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
      .out_inum(out_inum), .out_pc(out_pc), .out_reg(out_reg),
      .out_value(out_value), .out_addr(out_addr), .out_mdata(out_mdata),
      .full(full), .overflow(overflow), .inst_count(inst_count),
      .cycle_count(cycle_count), .done(done)
`ifdef COMMIT_TRACE_STALL_EN
      , .commit_stall(commit_stall)
`endif
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      logic [2:0]  kind;
      logic [15:0] inum;
      logic [15:0] pc;
      logic [2:0]  rg;
      logic [15:0] val;
      logic [15:0] addr;
      logic [15:0] mdata;
   } rec_t;

   rec_t        q[$];
   int          m_state;   // 0 run, 1 drain, 2 done
   bit          m_ovf;
   logic [15:0] m_inst;
   logic [31:0] m_cyc;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_state = 0;
      m_ovf   = 1'b0;
      m_inst  = '0;
      m_cyc   = '0;
   endtask

   function automatic rec_t classify();
      rec_t r;
      r.kind = 3'd0; r.inum = '0; r.pc = commit_pc; r.rg = '0;
      r.val = '0; r.addr = '0; r.mdata = '0;
      if (halt) r.kind = 3'd5;
      else if (reg_write && mem_write) begin
         r.kind = 3'd4; r.rg = write_reg; r.val = write_data;
         r.addr = mem_addr; r.mdata = mem_data;
      end else if (reg_write && mem_read) begin
         r.kind = 3'd2; r.rg = write_reg; r.val = write_data; r.addr = mem_addr;
      end else if (reg_write) begin
         r.kind = 3'd1; r.rg = write_reg; r.val = write_data;
      end else if (mem_write) begin
         r.kind = 3'd3; r.addr = mem_addr; r.mdata = mem_data;
      end
      return r;
   endfunction

   // Advance the model across one rising edge using the inputs currently driven.
   task automatic model_update();
      int   sz;
      int   nst;
      bit   fullm, pop, commit;
      rec_t r;
      if (rst) begin
         model_reset();
         return;
      end
      sz     = q.size();
      fullm  = (sz == DEPTH);
      pop    = (sz > 0) && out_ready;
      commit = (m_state == 0) && commit_valid;
`ifdef COMMIT_TRACE_STALL_EN
      if (fullm && !pop) commit = 1'b0;
`endif
      nst = m_state;
      if (m_state == 0) m_cyc = m_cyc + 32'd1;
      if (m_state == 1 && sz == 0) nst = 2;
      if (pop) q.delete(0);
      if (commit) begin
         r = classify();
         r.inum = m_inst;
         if (!fullm || pop) q.push_back(r);
         else m_ovf = 1'b1;
         m_inst = m_inst + 16'd1;
         if (halt) nst = 1;
      end
      m_state = nst;
   endtask

   task automatic check_all();
      rec_t h;
      bit   v;
      v = (q.size() != 0);
      if (v) h = q[0];
      else begin
         h.kind = '0; h.inum = '0; h.pc = '0; h.rg = '0;
         h.val = '0; h.addr = '0; h.mdata = '0;
      end
      chk("out_valid",   32'(out_valid),   32'(v));
      chk("out_kind",    32'(out_kind),    32'(h.kind));
      chk("out_inum",    32'(out_inum),    32'(h.inum));
      chk("out_pc",      32'(out_pc),      32'(h.pc));
      chk("out_reg",     32'(out_reg),     32'(h.rg));
      chk("out_value",   32'(out_value),   32'(h.val));
      chk("out_addr",    32'(out_addr),    32'(h.addr));
      chk("out_mdata",   32'(out_mdata),   32'(h.mdata));
      chk("full",        32'(full),        32'(q.size() == DEPTH));
      chk("overflow",    32'(overflow),    32'(m_ovf));
      chk("inst_count",  32'(inst_count),  32'(m_inst));
      chk("cycle_count", 32'(cycle_count), m_cyc);
      chk("done",        32'(done),        32'(m_state == 2));
`ifdef COMMIT_TRACE_STALL_EN
      chk("commit_stall", 32'(commit_stall),
          32'((q.size() == DEPTH) && !(v && out_ready)));
`endif
   endtask

   // One clock: compare at the falling edge, advance model, return #1 after rise.
   task automatic step();
      @(negedge clk);
      check_all();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      commit_valid = 1'b0; commit_pc = '0; reg_write = 1'b0; write_reg = '0;
      write_data = '0; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0;
      mem_data = '0; halt = 1'b0;
   endtask

   task automatic rand_commit(input int pct);
      commit_valid = ($urandom_range(0, 99) < pct);
      commit_pc    = 16'($urandom);
      reg_write    = 1'($urandom);
      write_reg    = 3'($urandom);
      write_data   = 16'($urandom);
      mem_read     = 1'($urandom);
      mem_write    = 1'($urandom);
      mem_addr     = 16'($urandom);
      mem_data     = 16'($urandom);
      halt         = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      step();
      rst = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      out_ready = 1'b0;
      idle();
      model_reset();
      step();
      step();
      rst = 1'b0;

      // REG then ST with the sink always ready
      out_ready = 1'b1;
      idle();
      commit_valid = 1'b1; commit_pc = 16'h0000; reg_write = 1'b1;
      write_reg = 3'd3; write_data = 16'h1234; mem_addr = 16'h5555; mem_data = 16'h7777;
      step();
      chk("reg_vld",   32'(out_valid), 32'd1);
      chk("reg_kind",  32'(out_kind),  32'd1);
      chk("reg_inum",  32'(out_inum),  32'd0);
      chk("reg_reg",   32'(out_reg),   32'd3);
      chk("reg_value", 32'(out_value), 32'h1234);
      chk("reg_addr",  32'(out_addr),  32'd0);
      idle();
      commit_valid = 1'b1; commit_pc = 16'h0002; mem_write = 1'b1;
      mem_addr = 16'h0040; mem_data = 16'hBEEF; write_reg = 3'd5; write_data = 16'h9999;
      step();
      chk("st_kind",  32'(out_kind),  32'd3);
      chk("st_inum",  32'(out_inum),  32'd1);
      chk("st_pc",    32'(out_pc),    32'h0002);
      chk("st_addr",  32'(out_addr),  32'h0040);
      chk("st_mdata", 32'(out_mdata), 32'hBEEF);
      chk("st_reg",   32'(out_reg),   32'd0);
      chk("st_value", 32'(out_value), 32'd0);
      idle();
      step();
      chk("empty_rdy_vld", 32'(out_valid), 32'd0);

      // Fill to DEPTH, then one more commit with no pop
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         idle(); commit_valid = 1'b1; commit_pc = 16'(2 * i);
         step();
      end
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_ovf0", 32'(overflow), 32'd0);
      idle(); commit_valid = 1'b1; commit_pc = 16'h0100;
`ifdef COMMIT_TRACE_STALL_EN
      chk("stall_when_full", 32'(commit_stall), 32'd1);
`endif
      step();
`ifdef COMMIT_TRACE_STALL_EN
      chk("ovf_tied0",   32'(overflow),   32'd0);
      chk("stall_inst8", 32'(inst_count), 32'd8);
`else
      chk("ovf_set",     32'(overflow),   32'd1);
      chk("drop_inst9",  32'(inst_count), 32'd9);
`endif
      idle();
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         chk("drain_inum", 32'(out_inum), 32'(i));
         step();
      end
      chk("drained_vld", 32'(out_valid), 32'd0);

      // Full with simultaneous push and pop
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         idle(); commit_valid = 1'b1; commit_pc = 16'(i);
         step();
      end
      idle(); commit_valid = 1'b1; reg_write = 1'b1; write_reg = 3'd7;
      out_ready = 1'b1;
      step();
      chk("pp_full",  32'(full),       32'd1);
      chk("pp_ovf",   32'(overflow),   32'd0);
      chk("pp_head",  32'(out_inum),   32'd1);
      chk("pp_inst",  32'(inst_count), 32'd9);
      idle();
      for (int i = 0; i < DEPTH + 2; i++) step();
      chk("pp_drained", 32'(out_valid), 32'd0);

      // Randomized traffic at several sink rates
      do_reset();
      for (int ph = 0; ph < 3; ph++) begin
         for (int c = 0; c < 500; c++) begin
            rand_commit(60);
            out_ready = ($urandom_range(0, 99) < (ph == 0 ? 20 : (ph == 1 ? 55 : 90)));
            step();
         end
      end
      idle();
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++) step();

      // LD, HALT, stray commit, drain to done
      do_reset();
      out_ready = 1'b0;
      idle(); commit_valid = 1'b1; commit_pc = 16'h0008; reg_write = 1'b1;
      mem_read = 1'b1; write_reg = 3'd2; write_data = 16'hABCD; mem_addr = 16'h0080;
      mem_data = 16'h1111;
      step();
      idle(); commit_valid = 1'b1; commit_pc = 16'h000A; halt = 1'b1; reg_write = 1'b1;
      step();
      idle(); commit_valid = 1'b1; commit_pc = 16'h000C; reg_write = 1'b1;
      step();
      idle();
      step(); step();
      chk("halt_cyc_frozen", cycle_count, 32'd2);
      chk("halt_inst",       32'(inst_count), 32'd2);
      chk("halt_done0",      32'(done), 32'd0);
      chk("ld_kind",         32'(out_kind), 32'd2);
      chk("ld_mdata",        32'(out_mdata), 32'd0);
      out_ready = 1'b1;
      step();
      chk("halt_kind",  32'(out_kind), 32'd5);
      chk("halt_inum",  32'(out_inum), 32'd1);
      chk("halt_pc",    32'(out_pc),   32'h000A);
      chk("halt_reg",   32'(out_reg),  32'd0);
      chk("halt_done1", 32'(done),     32'd0);
      step();
      chk("last_pop_vld", 32'(out_valid), 32'd0);
      chk("last_pop_done", 32'(done), 32'd0);
      step();
      chk("done_set", 32'(done), 32'd1);
      idle(); commit_valid = 1'b1; reg_write = 1'b1;
      step();
      chk("done_ignores", 32'(inst_count), 32'd2);
      chk("done_cyc",     cycle_count, 32'd2);

      // Asynchronous reset with records buffered
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rand_commit(100);
         step();
      end
      idle();
      #2;
      rst = 1'b1;
      #1;
      chk("arst_vld",  32'(out_valid),   32'd0);
      chk("arst_inst", 32'(inst_count),  32'd0);
      chk("arst_cyc",  cycle_count,      32'd0);
      chk("arst_kind", 32'(out_kind),    32'd0);
      chk("arst_pc",   32'(out_pc),      32'd0);
      chk("arst_done", 32'(done),        32'd0);
      model_reset();
      step();
      rst = 1'b0;
      idle(); commit_valid = 1'b1; reg_write = 1'b1; write_reg = 3'd1; write_data = 16'h00AA;
      step();
      chk("post_rst_vld",  32'(out_valid), 32'd1);
      chk("post_rst_inum", 32'(out_inum),  32'd0);
      idle();
      out_ready = 1'b1;
      step(); step();

`ifdef COMMIT_TRACE_STALL_EN
      // Held commit against a full FIFO, then released by the sink
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         idle(); commit_valid = 1'b1; commit_pc = 16'(i);
         step();
      end
      idle(); commit_valid = 1'b1; commit_pc = 16'h0020;
      chk("hold_stall", 32'(commit_stall), 32'd1);
      step();
      chk("hold_inst", 32'(inst_count), 32'd8);
      out_ready = 1'b1;
      chk("release_stall", 32'(commit_stall), 32'd0);
      step();
      chk("release_inst", 32'(inst_count), 32'd9);
      chk("release_ovf",  32'(overflow),   32'd0);
      chk("release_full", 32'(full),       32'd1);
      idle();
      for (int i = 0; i < DEPTH + 2; i++) step();
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/commit_trace_buf.md
Name: commit_trace_buf

Overview:
- Sits directly downstream of the processor's retire/writeback point and consumes its per-instruction commit signals (PC, register write, memory access, halt).
- Classifies each retiring instruction into a trace record, numbers it, and buffers it in a FIFO.
- Drains records over a valid/ready port to a trace sink (UART/host logger).
- Also maintains cycle and instruction counters and signals completion after halt.

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2.
- CNT_W, 32, width of cycle_count.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- commit_valid  in  1  one instruction retires this cycle.
- commit_pc  in  16  PC of the retiring instruction.
- reg_write  in  1  register file written.
- write_reg  in  3  destination register.
- write_data  in  16  register write data.
- mem_read  in  1  load.
- mem_write  in  1  store.
- mem_addr  in  16  memory address.
- mem_data  in  16  store data.
- halt  in  1  retiring instruction is HALT.
- out_valid  out  1  record available.
- out_ready  in  1  sink accepts the record.
- out_kind  out  3  0=OTHER, 1=REG, 2=LD, 3=ST, 4=STU, 5=HALT.
- out_inum  out  16  instruction number, starting at 0.
- out_pc  out  16  record PC.
- out_reg  out  3  destination register (0 if unused).
- out_value  out  16  register write data (0 if unused).
- out_addr  out  16  memory address (0 if unused).
- out_mdata  out  16  store data (0 if unused).
- full  out  1  FIFO occupancy == DEPTH.
- overflow  out  1  sticky; a record was dropped.
- inst_count  out  16  instructions retired.
- cycle_count  out  CNT_W  cycles spent in RUN.
- done  out  1  halt seen and FIFO fully drained.

Behaviour:
- Reset (async, rst=1): FIFO empty, state=RUN. All outputs 0: out_valid, out_* fields, full, overflow, counters, done. Reset mid-operation discards all buffered records immediately.
- Classification, evaluated when commit_valid=1, priority top-down:
  - halt → HALT.
  - reg_write & mem_write → STU.
  - reg_write & mem_read → LD.
  - reg_write → REG.
  - mem_write → ST.
  - otherwise → OTHER.
  - Fields not meaningful for the kind are stored as 0. Example: ST stores reg=0, value=0.
- out_inum = inst_count value before the increment for that commit.
- State machine:
  - RUN:
    - cycle_count += 1 every cycle.
    - Each commit_valid pushes one record and increments inst_count (mod 2^16).
    - HALT commit: push it, then go to DRAIN on the next edge.
  - DRAIN:
    - commit_valid ignored; counters frozen.
    - When FIFO occupancy reaches 0 → DONE.
  - DONE: done=1; stays until reset; commits ignored.
- FIFO:
  - First-word fall-through: out_* present the head record whenever out_valid=1.
  - Pop on out_valid & out_ready.
  - Push into an empty FIFO: out_valid=1 the following cycle, giving 1-cycle latency.
  - out_* hold stable while out_valid & !out_ready.
- Boundary conditions:
  - Full, with simultaneous push and pop: both occur and occupancy is unchanged.
  - Full, push with no pop: record dropped, overflow←1 (sticky until reset), inst_count still increments so out_inum gaps reveal the loss. A dropped HALT still transitions to DRAIN.
  - Empty with out_ready=1: no pop, out_valid=0.
  - Pointers wrap modulo DEPTH.
  - inst_count wraps 0xFFFF→0.
  - cycle_count wraps at 2^CNT_W.

Optional Feature:
- Macro: COMMIT_TRACE_STALL_EN.
- Defined:
  - Extra output commit_stall (1 bit) = full & !(out_valid & out_ready).
  - The processor must hold its commit while commit_stall=1.
  - A commit presented while commit_stall=1 is not pushed and not counted.
  - overflow is tied to 0.
- Not defined: no commit_stall port; drop-and-flag overflow behaviour as above.

Test Plan:
- Reset, then out_ready=1; commit REG pc=0x0000 r3=0x1234, then ST pc=0x0002 addr=0x0040 data=0xBEEF → records (kind1, inum0, reg3, 0x1234) and (kind3, inum1, addr0x0040, mdata0xBEEF), each appearing 1 cycle after its commit.
- out_ready=0; 8 OTHER commits then a 9th commit (DEPTH=8) → full=1, overflow=1. After draining, inums read 0..7; inst_count=9.
- FIFO full, push and pop in the same cycle → occupancy stays 8, no overflow, head advances by one.
- Commit LD then HALT at pc=0x000A, then a stray commit → HALT record kind5 inum1; stray commit ignored; done=1 only after the last pop; cycle_count frozen.
- Assert rst with 5 records buffered → out_valid=0, counters=0, state=RUN, all within the same cycle (asynchronous).
- With COMMIT_TRACE_STALL_EN: fill FIFO → commit_stall=1, held commit not counted; raise out_ready → commit accepted next cycle, overflow stays 0.
